bram_word_loader: RTL and testbench
===================================

Name: bram_word_loader

Overview:
- Byte-stream front end feeding the single-port BRAM (SPBRAM) write port.
- Accepts bytes over a valid/ready handshake and packs them little-endian into 32-bit words.
- Issues one single-cycle word write per packed word, at incrementing word addresses.
- Used at boot to load program/data images (e.g. from the UART receiver) into BRAM before the core is released.

Parameters:
- ADDRESS_BITWIDTH, 16, BRAM word-address width; capacity is 2^ADDRESS_BITWIDTH words.
- START_ADDRESS, 0, word address of the first write after start.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a load; honoured only in IDLE or DONE
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_last  input  1  qualifies in_data as the final byte of the image
- in_ready  output  1  loader accepts a byte this cycle
- bram_write_enable  output  1  to SPBRAM write_enable
- bram_address  output  32  to SPBRAM address (word address, zero-extended)
- bram_data_in  output  32  to SPBRAM data_in
- busy  output  1  high in COLLECT and WRITE
- done  output  1  high in DONE
- overflow  output  1  sticky; image exceeded BRAM capacity
- word_count  output  ADDRESS_BITWIDTH+1  words written in the current load

Behaviour:
- Reset (async, takes effect immediately):
  - State IDLE.
  - All outputs 0; bram_address = START_ADDRESS.
  - Byte lane index 0; partial word discarded; no write is issued.
- A byte is accepted when in_valid && in_ready at a rising edge.
- FSM states: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - in_ready = 0.
  - start -> COLLECT; clears word_count, overflow and lane; sets bram_address = START_ADDRESS.
- COLLECT:
  - in_ready = 1.
  - Accepted byte goes to lane k, bits [8k+7:8k]. Lane 0 is the first byte of the word; lane k resets to 0 at each word start.
  - Transition to WRITE when the lane-3 byte is accepted, or when any byte is accepted with in_last = 1.
  - On a partial word, unfilled lanes are 0.
- WRITE (exactly one cycle):
  - bram_write_enable = 1; bram_address and bram_data_in are stable; in_ready = 0.
  - On exit: word_count += 1 and bram_address += 1.
  - Next state is DONE if the word held the last byte; otherwise COLLECT.
- Timing:
  - Byte completing a word is accepted at edge N; write_enable is high between edges N and N+1, and the BRAM captures at edge N+1.
  - Sustained throughput is 4 bytes per 5 cycles.
- DONE:
  - in_ready = 0; done = 1.
  - Holds until start (restarts, same as from IDLE) or rst.
- Overflow:
  - If a word completes while word_count equals 2^ADDRESS_BITWIDTH - START_ADDRESS, no write is issued.
  - overflow is set to 1 and the state goes to DONE.
  - Remaining stream bytes are not accepted.
- bram_address never wraps past 2^ADDRESS_BITWIDTH - 1; upper bits of bram_address are always 0.
- Boundary cases:
  - start while busy: ignored.
  - in_last on the lane-3 byte: single full-word write, then DONE.
  - in_valid while not in COLLECT: ignored; no byte is consumed.
  - in_data and in_last are sampled only on acceptance.
- Reset mid-load: no partial write. If rst asserts during WRITE, the write is aborted asynchronously; the bench must not rely on the BRAM capturing that word.
- bram_data_in holds its last value outside WRITE (don't-care for the BRAM while write_enable = 0).

Test Plan:
1. Full words, START_ADDRESS = 0. start, then stream 0x12,0xef,0xcd,0xab,0x78,0x56,0x34,0x12 with in_last on the final byte, in_valid held high. Required:
   - write addr 0 data 0xabcdef12;
   - write addr 1 data 0x12345678;
   - done = 1, word_count = 2;
   - BRAM readback of addresses 0 and 1 matches.
2. Partial word: stream 0x11,0x22,0x33,0x44,0x55,0x66 with in_last on 0x66. Required:
   - writes 0x44332211 @0 and 0x00006655 @1;
   - exactly 2 write_enable pulses.
3. Backpressure and gaps:
   - randomly deassert in_valid during scenario 1 -> identical writes;
   - in_ready = 0 in every WRITE cycle;
   - each write_enable pulse lasts exactly 1 cycle.
4. Overflow: ADDRESS_BITWIDTH = 2, START_ADDRESS = 2, stream 16 bytes. Required:
   - writes only at addresses 2 and 3;
   - overflow = 1, done = 1, word_count = 2;
   - in_ready = 0 for the remaining bytes.
5. Reset mid-operation: assert rst after 3 bytes, and separately during a WRITE cycle. Required:
   - outputs return to 0 immediately, no write occurs;
   - after release, start plus a new stream loads from START_ADDRESS with a fresh word_count.
6. Restart from DONE: finish scenario 2, pulse start, stream 0xaa with in_last. Required:
   - write 0x000000aa @0, word_count = 1;
   - start pulsed during COLLECT has no effect.

Source files
------------

// File: rtl/bram_word_loader.sv
// Boot-time byte-stream loader: packs accepted bytes little-endian into 32-bit
// words and issues one single-cycle SPBRAM write per word at incrementing addresses.
module bram_word_loader #(
  parameter int ADDRESS_BITWIDTH = 16,
  parameter int START_ADDRESS    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic                      bram_write_enable,
  output logic [31:0]               bram_address,
  output logic [31:0]               bram_data_in,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic [ADDRESS_BITWIDTH:0] word_count
);

  localparam int AW = ADDRESS_BITWIDTH;
  localparam logic [AW-1:0] START     = AW'(START_ADDRESS);
  localparam logic [AW-1:0] LAST_ADDR = '1;
  localparam logic [AW:0]   CAPACITY  = (AW+1)'((1 << AW) - START_ADDRESS);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    lane_q, lane_d;
  logic [31:0]   word_q, word_d;
  logic [31:0]   data_q, data_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          last_q, last_d;
  logic [31:0]   word_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lane_q  <= 2'd0;
      word_q  <= 32'h0;
      data_q  <= 32'h0;
      addr_q  <= START;
      count_q <= '0;
      ovf_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
    end
  end

  // Lane 0 opens a new word, so stale upper lanes are cleared there.
  always_comb begin
    if (lane_q == 2'd0) begin
      word_next = {24'h0, in_data};
    end else begin
      word_next = word_q;
      word_next[{lane_q, 3'b000} +: 8] = in_data;
    end
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    word_d  = word_q;
    data_d  = data_q;
    addr_d  = addr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_COLLECT;
          lane_d  = 2'd0;
          addr_d  = START;
          count_d = '0;
          ovf_d   = 1'b0;
          last_d  = 1'b0;
        end
      end
      S_COLLECT: begin
        if (in_valid) begin
          word_d = word_next;
          if (lane_q == 2'd3 || in_last) begin
            lane_d = 2'd0;
            last_d = in_last;
            // A word that would land past the top of BRAM is dropped.
            if (count_q == CAPACITY) begin
              ovf_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              data_d  = word_next;
              state_d = S_WRITE;
            end
          end else begin
            lane_d = lane_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        count_d = count_q + 1'b1;
        if (addr_q != LAST_ADDR) addr_d = addr_q + 1'b1;
        state_d = last_q ? S_DONE : S_COLLECT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready          = (state_q == S_COLLECT);
  assign bram_write_enable = (state_q == S_WRITE);
  assign busy              = (state_q == S_COLLECT) || (state_q == S_WRITE);
  assign done              = (state_q == S_DONE);
  assign overflow          = ovf_q;
  assign word_count        = count_q;
  assign bram_address      = 32'(addr_q);
  assign bram_data_in      = data_q;

endmodule

// File: tb/tb_bram_word_loader.sv
// Bench for bram_word_loader: a 64K-word instance for normal loads and a
// 4-word instance starting at address 2 for capacity overflow.
module tb_bram_word_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start0, start1, in_valid, in_last;
  logic [7:0]  in_data;

  logic        rdy0, we0, busy0, done0, ovf0;
  logic [31:0] addr0, dat0;
  logic [16:0] wc0;
  logic        rdy1, we1, busy1, done1, ovf1;
  logic [31:0] addr1, dat1;
  logic [2:0]  wc1;

  bram_word_loader #(.ADDRESS_BITWIDTH(16), .START_ADDRESS(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rdy0), .bram_write_enable(we0), .bram_address(addr0),
    .bram_data_in(dat0), .busy(busy0), .done(done0), .overflow(ovf0), .word_count(wc0));

  bram_word_loader #(.ADDRESS_BITWIDTH(2), .START_ADDRESS(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rdy1), .bram_write_enable(we1), .bram_address(addr1),
    .bram_data_in(dat1), .busy(busy1), .done(done1), .overflow(ovf1), .word_count(wc1));

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct packed {
    logic [4:0]   n;
    logic         gaps;
    logic [127:0] bytes;
    logic [2:0]   nw;
    logic [127:0] words;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  wr_t wr0[$];
  wr_t wr1[$];
  logic [31:0] mem0 [int];
  logic [31:0] mem1 [int];
  logic [7:0]  bq[$];
  logic we0_prev = 1'b0;
  logic we1_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor plus behavioural BRAM images.
  always @(negedge clk) begin
    if (we0) begin
      wr0.push_back('{a: addr0, d: dat0});
      mem0[int'(addr0)] = dat0;
      check("ready_low_in_write0", {63'h0, rdy0}, 64'h0);
      check("we_single_cycle0", {63'h0, we0_prev}, 64'h0);
    end
    if (we1) begin
      wr1.push_back('{a: addr1, d: dat1});
      mem1[int'(addr1)] = dat1;
      check("ready_low_in_write1", {63'h0, rdy1}, 64'h0);
      check("we_single_cycle1", {63'h0, we1_prev}, 64'h0);
    end
    we0_prev <= we0;
    we1_prev <= we1;
  end

  task automatic pulse_start(input bit use1);
    @(negedge clk);
    if (use1) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic send_stream(input bit use1, input bit gaps, input bit mark_last, output int acc);
    bit stop;
    bit got;
    int waited;
    stop = 1'b0;
    acc = 0;
    for (int i = 0; i < bq.size() && !stop; i++) begin
      got = 1'b0;
      waited = 0;
      while (!got && !stop) begin
        @(negedge clk);
        if (use1 ? done1 : done0) begin
          stop = 1'b1;
        end else begin
          in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
          in_data  = bq[i];
          in_last  = mark_last && (i == bq.size() - 1);
          got = in_valid && (use1 ? rdy1 : rdy0);
          @(posedge clk);
          waited++;
          if (!got && waited > 40) begin
            n_tests++;
            n_fail++;
            $display("FAIL stream_timeout: byte %0d not accepted after %0d cycles", i, waited);
            stop = 1'b1;
          end
        end
      end
      if (got) acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input bit use1);
    int k;
    k = 0;
    while (!(use1 ? done1 : done0) && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Reference: ceil(n/4) little-endian words, zero-padded, clipped at capacity.
  task automatic model(input int start_addr, input int cap, output wr_t exp[$],
                       output bit ovf, output int acc_e);
    int n, nw;
    logic [31:0] v;
    n  = bq.size();
    nw = (n + 3) / 4;
    exp.delete();
    for (int w = 0; w < nw && w < cap; w++) begin
      v = 32'h0;
      for (int k = 0; k < 4; k++)
        if (4 * w + k < n) v = v | (32'(bq[4 * w + k]) << (8 * k));
      exp.push_back('{a: 32'(start_addr + w), d: v});
    end
    ovf = (nw > cap);
    acc_e = ovf ? ((4 * (cap + 1) < n) ? 4 * (cap + 1) : n) : n;
  endtask

  task automatic check_load(input bit use1, input string nm, input wr_t exp[$],
                            input bit ovf_e, input int acc, input int acc_e);
    wr_t got[$];
    logic [31:0] rb;
    if (use1) got = wr1; else got = wr0;
    check({nm, "_nwrites"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      check({nm, "_addr"}, {32'h0, got[i].a}, {32'h0, exp[i].a});
      check({nm, "_data"}, {32'h0, got[i].d}, {32'h0, exp[i].d});
    end
    for (int i = 0; i < exp.size(); i++) begin
      rb = 32'hdeadbeef;
      if (use1) begin
        if (mem1.exists(int'(exp[i].a))) rb = mem1[int'(exp[i].a)];
      end else begin
        if (mem0.exists(int'(exp[i].a))) rb = mem0[int'(exp[i].a)];
      end
      check({nm, "_readback"}, {32'h0, rb}, {32'h0, exp[i].d});
    end
    check({nm, "_done"}, {63'h0, (use1 ? done1 : done0)}, 64'h1);
    check({nm, "_busy"}, {63'h0, (use1 ? busy1 : busy0)}, 64'h0);
    check({nm, "_overflow"}, {63'h0, (use1 ? ovf1 : ovf0)}, {63'h0, ovf_e});
    check({nm, "_word_count"}, 64'(use1 ? 17'(wc1) : wc0), 64'(exp.size()));
    check({nm, "_accepted"}, 64'(acc), 64'(acc_e));
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_busy0"}, {63'h0, busy0}, 64'h0);
    check({nm, "_done0"}, {63'h0, done0}, 64'h0);
    check({nm, "_we0"}, {63'h0, we0}, 64'h0);
    check({nm, "_ready0"}, {63'h0, rdy0}, 64'h0);
    check({nm, "_ovf0"}, {63'h0, ovf0}, 64'h0);
    check({nm, "_wc0"}, 64'(wc0), 64'h0);
    check({nm, "_addr0"}, {32'h0, addr0}, 64'h0);
    check({nm, "_data0"}, {32'h0, dat0}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    wr_t  exp[$];
    bit   ovf_e;
    int   acc, acc2, acc_e, n;

    vecs[0] = '{n: 5'd8, gaps: 1'b0, bytes: 128'h12345678abcdef12, nw: 3'd2, words: 128'h12345678_abcdef12};
    vecs[1] = '{n: 5'd8, gaps: 1'b1, bytes: 128'h12345678abcdef12, nw: 3'd2, words: 128'h12345678_abcdef12};
    vecs[2] = '{n: 5'd6, gaps: 1'b0, bytes: 128'h665544332211, nw: 3'd2, words: 128'h00006655_44332211};
    vecs[3] = '{n: 5'd1, gaps: 1'b0, bytes: 128'haa, nw: 3'd1, words: 128'h000000aa};
    vecs[4] = '{n: 5'd4, gaps: 1'b1, bytes: 128'h04030201, nw: 3'd1, words: 128'h04030201};

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    #1;
    check_reset_outputs("reset");
    check("reset_addr1", {32'h0, addr1}, 64'h2);
    check("reset_busy1", {63'h0, busy1}, 64'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // in_valid while idle must not be consumed.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h5a;
    @(negedge clk);
    check("idle_ready", {63'h0, rdy0}, 64'h0);
    in_valid = 1'b0;

    for (int v = 0; v < 5; v++) begin
      pulse_start(1'b0);
      wr0.delete();
      bq.delete();
      for (int i = 0; i < int'(vecs[v].n); i++) bq.push_back(vecs[v].bytes[8 * i +: 8]);
      send_stream(1'b0, vecs[v].gaps, 1'b1, acc);
      wait_done(1'b0);
      exp.delete();
      for (int i = 0; i < int'(vecs[v].nw); i++)
        exp.push_back('{a: 32'(i), d: vecs[v].words[32 * i +: 32]});
      check_load(1'b0, $sformatf("vec%0d", v), exp, 1'b0, acc, int'(vecs[v].n));
    end

    // start during COLLECT is ignored.
    pulse_start(1'b0);
    wr0.delete();
    bq.delete(); bq.push_back(8'h01); bq.push_back(8'h02);
    send_stream(1'b0, 1'b0, 1'b0, acc);
    pulse_start(1'b0);
    check("start_in_collect_busy", {63'h0, busy0}, 64'h1);
    bq.delete(); bq.push_back(8'h03); bq.push_back(8'h04); bq.push_back(8'h05);
    send_stream(1'b0, 1'b0, 1'b1, acc2);
    wait_done(1'b0);
    bq.delete();
    for (int i = 1; i <= 5; i++) bq.push_back(8'(i));
    model(0, 65536, exp, ovf_e, acc_e);
    check_load(1'b0, "start_ignored", exp, ovf_e, acc + acc2, acc_e);

    // Reset after three bytes.
    pulse_start(1'b0);
    wr0.delete();
    bq.delete(); bq.push_back(8'hc1); bq.push_back(8'hc2); bq.push_back(8'hc3);
    send_stream(1'b0, 1'b0, 1'b0, acc);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_nowrite", 64'(wr0.size()), 64'h0);

    // Reset while the WRITE cycle is in progress.
    pulse_start(1'b0);
    wr0.delete();
    bq.delete(); bq.push_back(8'hd1); bq.push_back(8'hd2); bq.push_back(8'hd3);
    send_stream(1'b0, 1'b0, 1'b0, acc);
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hd4;
    @(posedge clk);
    #1;
    check("write_entered", {63'h0, we0}, 64'h1);
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_write");
    @(negedge clk);
    check("rst_write_nowrite", 64'(wr0.size()), 64'h0);
    rst = 1'b0;

    // Fresh load after reset starts at START_ADDRESS.
    pulse_start(1'b0);
    wr0.delete();
    bq.delete();
    for (int i = 0; i < 6; i++) bq.push_back(8'(8'h11 * (i + 1)));
    send_stream(1'b0, 1'b0, 1'b1, acc);
    wait_done(1'b0);
    model(0, 65536, exp, ovf_e, acc_e);
    check_load(1'b0, "after_reset", exp, ovf_e, acc, acc_e);

    // Randomized loads against the reference model.
    for (int r = 0; r < 6; r++) begin
      pulse_start(1'b0);
      wr0.delete();
      bq.delete();
      n = int'($urandom_range(1, 40));
      for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
      send_stream(1'b0, 1'($urandom_range(0, 1)), 1'b1, acc);
      wait_done(1'b0);
      model(0, 65536, exp, ovf_e, acc_e);
      check_load(1'b0, $sformatf("rand%0d", r), exp, ovf_e, acc, acc_e);
    end

    // Overflow on the 4-word instance starting at address 2.
    pulse_start(1'b1);
    wr1.delete();
    bq.delete();
    for (int i = 0; i < 16; i++) bq.push_back(8'(8'h30 + i));
    send_stream(1'b1, 1'b0, 1'b1, acc);
    wait_done(1'b1);
    model(2, 2, exp, ovf_e, acc_e);
    check_load(1'b1, "overflow", exp, ovf_e, acc, acc_e);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'hee;
      #1;
      check("overflow_ready_low", {63'h0, rdy1}, 64'h0);
    end
    @(negedge clk);
    in_valid = 1'b0;

    for (int r = 0; r < 4; r++) begin
      pulse_start(1'b1);
      wr1.delete();
      bq.delete();
      n = int'($urandom_range(1, 20));
      for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
      send_stream(1'b1, 1'($urandom_range(0, 1)), 1'b1, acc);
      wait_done(1'b1);
      model(2, 2, exp, ovf_e, acc_e);
      check_load(1'b1, $sformatf("rand_small%0d", r), exp, ovf_e, acc, acc_e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
